tape_dma_ctrl: RTL and testbench

Sequencer and RAM-port arbiter for fast .P file loading in the ZX80/ZX81 core. It traps the CPU's M1 fetch at the ROM LOAD entry and substitutes a 7-byte spin-loop patch on the CPU data bus. While the CPU spins, it copies the tape buffer into main RAM, then releases the CPU with carry set so the ROM continues at 0x0207. It sits between the CPU bus, the tape buffer RAM and the main RAM write port, and owns that port during a copy.

---
 rtl/tape_dma_pkg.sv | 32 +++
 rtl/tape_dma_arb.sv | 36 +++
 rtl/tape_dma_ctrl.sv | 156 +++++++++++++++
 tb/tb_tape_dma_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tape_dma_pkg.sv
// Shared constants and types for the fast .P file loader.
// Holds the trap/exit addresses, the spin-loop patch bytes and the sequencer state type.
package tape_dma_pkg;

    localparam logic [15:0] TRAP_ADDR   = 16'h0347;
    localparam logic [15:0] EXIT_ADDR   = 16'h03C3;
    localparam logic [13:0] DEST_OFFSET = 14'h0008;

    localparam logic [7:0] NOP = 8'h00;
    localparam logic [7:0] SCF = 8'h37;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        COPY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Byte 1 is stored as SCF; while copying it is replaced by NOP so the loop keeps spinning.
    localparam logic [6:0][7:0] PATCH_ROM = {8'h02, 8'h07, 8'hC3, 8'hFD, 8'h30, SCF, 8'hAF};

    function automatic logic [7:0] patch_byte(input logic [15:0] offset, input logic copying);
        logic [7:0] b;
        b = NOP;
        if (offset == 16'd1) begin
            b = copying ? NOP : SCF;
        end else if (offset <= 16'd6) begin
            b = PATCH_ROM[offset[2:0]];
        end
        return b;
    endfunction

endpackage

// File: rtl/tape_dma_arb.sv
// Main-RAM write-port mux: DMA owns the port while selected, otherwise the CPU passes straight through.
// A CPU write arriving while the DMA owns the port is dropped and latched in a sticky conflict flag.
module tape_dma_arb
    import tape_dma_pkg::*;
(
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        i_sel_dma,
    input  logic        i_cpu_we,
    input  logic [13:0] i_cpu_addr,
    input  logic [7:0]  i_cpu_din,
    input  logic        i_dma_we,
    input  logic [13:0] i_dma_addr,
    input  logic [7:0]  i_dma_din,
    output logic        o_we,
    output logic [13:0] o_addr,
    output logic [7:0]  o_din,
    output logic        o_conflict
);

    logic r_conflict;

    assign o_we       = i_sel_dma ? i_dma_we   : i_cpu_we;
    assign o_addr     = i_sel_dma ? i_dma_addr : i_cpu_addr;
    assign o_din      = i_sel_dma ? i_dma_din  : i_cpu_din;
    assign o_conflict = r_conflict;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_conflict <= 1'b0;
        end else if (i_sel_dma && i_cpu_we) begin
            r_conflict <= 1'b1;
        end
    end

endmodule

// File: rtl/tape_dma_ctrl.sv
// Fast .P loader: traps the ROM LOAD entry, feeds the CPU a spin-loop patch and copies the tape buffer into RAM.
// Optional build macro TAPE_DMA_CHECKSUM_EN adds an 8-bit running sum of the bytes written.
module tape_dma_ctrl
    import tape_dma_pkg::*;
(
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_nm1,
    input  logic        cpu_ram_we,
    input  logic [13:0] cpu_ram_addr,
    input  logic [7:0]  cpu_dout,
    input  logic        tape_ready,
    input  logic [13:0] tape_last,
    output logic [13:0] tape_rd_addr,
    input  logic [7:0]  tape_rd_data,
    output logic        ram_we,
    output logic [13:0] ram_addr,
    output logic [7:0]  ram_din,
    output logic        patch_sel,
    output logic [7:0]  patch_data,
    output logic        busy,
    output logic        load_done,
    output logic        load_abort,
    output logic        cpu_conflict
`ifdef TAPE_DMA_CHECKSUM_EN
    ,
    output logic [7:0]  checksum
`endif
);

    state_t      r_state;
    logic        r_nm1_prev;
    logic [13:0] r_rd_addr;
    logic [13:0] r_wr_idx;
    logic        r_wr_valid;
    logic        r_issued;
    logic        r_load_done;
    logic        r_load_abort;

    logic        w_m1_edge;
    logic        w_exit_addr;
    logic        w_trap;
    logic        w_copying;
    logic        w_in_window;
    logic        w_dma_we;
    logic [13:0] w_dma_addr;

    assign w_m1_edge   = r_nm1_prev & ~cpu_nm1;
    assign w_exit_addr = (cpu_addr < TRAP_ADDR) || (cpu_addr >= EXIT_ADDR);
    assign w_trap      = w_m1_edge && (cpu_addr == TRAP_ADDR) && tape_ready;
    assign w_copying   = (r_state == COPY);
    assign w_in_window = (cpu_addr >= TRAP_ADDR) && (cpu_addr <= TRAP_ADDR + 16'd6);

    // Write stage: the byte fetched last cycle lands at its index plus the load offset.
    assign w_dma_we   = w_copying & r_wr_valid;
    assign w_dma_addr = r_wr_idx + DEST_OFFSET;

    assign tape_rd_addr = r_rd_addr;
    assign busy         = (r_state != IDLE);
    assign load_done    = r_load_done;
    assign load_abort   = r_load_abort;
    assign patch_sel    = busy & w_in_window;
    assign patch_data   = patch_sel ? patch_byte(cpu_addr - TRAP_ADDR, w_copying) : NOP;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state      <= IDLE;
            r_nm1_prev   <= 1'b0;
            r_rd_addr    <= 14'd0;
            r_wr_idx     <= 14'd0;
            r_wr_valid   <= 1'b0;
            r_issued     <= 1'b0;
            r_load_done  <= 1'b0;
            r_load_abort <= 1'b0;
        end else begin
            r_nm1_prev   <= cpu_nm1;
            r_load_done  <= 1'b0;
            r_load_abort <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_wr_valid <= 1'b0;
                    if (w_trap) begin
                        r_rd_addr <= 14'd0;
                        r_issued  <= 1'b0;
                        r_state   <= COPY;
                    end
                end
                COPY: begin
                    // Abort wins over completion; the byte in the write stage this cycle still lands.
                    if ((w_m1_edge && w_exit_addr) || !tape_ready) begin
                        r_load_abort <= 1'b1;
                        r_wr_valid   <= 1'b0;
                        r_state      <= IDLE;
                    end else if (r_wr_valid && r_issued) begin
                        r_wr_valid <= 1'b0;
                        r_state    <= DONE;
                    end else if (!r_issued) begin
                        r_wr_valid <= 1'b1;
                        r_wr_idx   <= r_rd_addr;
                        if (r_rd_addr == tape_last) begin
                            r_issued <= 1'b1;
                        end else begin
                            r_rd_addr <= r_rd_addr + 14'd1;
                        end
                    end else begin
                        r_wr_valid <= 1'b0;
                    end
                end
                DONE: begin
                    if (w_m1_edge && w_exit_addr) begin
                        r_load_done <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_wr_valid <= 1'b0;
                    r_state    <= IDLE;
                end
            endcase
        end
    end

`ifdef TAPE_DMA_CHECKSUM_EN
    logic [7:0] r_checksum;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_checksum <= 8'h00;
        end else if ((r_state == IDLE) && w_trap) begin
            r_checksum <= 8'h00;
        end else if (w_dma_we) begin
            r_checksum <= r_checksum + tape_rd_data;
        end
    end

    assign checksum = r_checksum;
`endif

    tape_dma_arb u_arb (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .i_sel_dma  (w_copying),
        .i_cpu_we   (cpu_ram_we),
        .i_cpu_addr (cpu_ram_addr),
        .i_cpu_din  (cpu_dout),
        .i_dma_we   (w_dma_we),
        .i_dma_addr (w_dma_addr),
        .i_dma_din  (tape_rd_data),
        .o_we       (ram_we),
        .o_addr     (ram_addr),
        .o_din      (ram_din),
        .o_conflict (cpu_conflict)
    );

endmodule

// File: tb/tb_tape_dma_ctrl.sv
// Self-checking bench for tape_dma_ctrl: directed loads plus randomized loads against a simple byte-copy model.
// Honours TAPE_DMA_CHECKSUM_EN when the design is built with it.
module tb_tape_dma_ctrl;

    localparam logic [15:0] T_TRAP = 16'h0347;
    localparam logic [13:0] T_DEST = 14'h0008;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic [15:0] cpu_addr;
    logic        cpu_nm1;
    logic        cpu_ram_we;
    logic [13:0] cpu_ram_addr;
    logic [7:0]  cpu_dout;
    logic        tape_ready;
    logic [13:0] tape_last;
    logic [13:0] tape_rd_addr;
    logic [7:0]  tape_rd_data;
    logic        ram_we;
    logic [13:0] ram_addr;
    logic [7:0]  ram_din;
    logic        patch_sel;
    logic [7:0]  patch_data;
    logic        busy;
    logic        load_done;
    logic        load_abort;
    logic        cpu_conflict;
`ifdef TAPE_DMA_CHECKSUM_EN
    logic [7:0]  checksum;
`endif

    logic [7:0] tape_mem [0:16383];
    int n_tests = 0;
    int n_fail  = 0;
    int wr_count = 0;
    bit exp_conflict = 1'b0;

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) tape_rd_data <= tape_mem[tape_rd_addr];
    always @(negedge clk_sys) if (ram_we === 1'b1) wr_count = wr_count + 1;

    tape_dma_ctrl dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .cpu_addr     (cpu_addr),
        .cpu_nm1      (cpu_nm1),
        .cpu_ram_we   (cpu_ram_we),
        .cpu_ram_addr (cpu_ram_addr),
        .cpu_dout     (cpu_dout),
        .tape_ready   (tape_ready),
        .tape_last    (tape_last),
        .tape_rd_addr (tape_rd_addr),
        .tape_rd_data (tape_rd_data),
        .ram_we       (ram_we),
        .ram_addr     (ram_addr),
        .ram_din      (ram_din),
        .patch_sel    (patch_sel),
        .patch_data   (patch_data),
        .busy         (busy),
        .load_done    (load_done),
        .load_abort   (load_abort),
        .cpu_conflict (cpu_conflict)
`ifdef TAPE_DMA_CHECKSUM_EN
        ,
        .checksum     (checksum)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic smp();
        @(negedge clk_sys);
    endtask

    // Patch ROM as seen by the CPU: only while loading, only inside 0347..034D.
    function automatic logic [7:0] exp_patch(input logic [15:0] a, input bit copying, input bit loading);
        logic [15:0] off;
        off = a - T_TRAP;
        if (!loading || a < T_TRAP || off > 16'd6) return 8'h00;
        case (off)
            16'd0:   return 8'hAF;
            16'd1:   return copying ? 8'h00 : 8'h37;
            16'd2:   return 8'h30;
            16'd3:   return 8'hFD;
            16'd4:   return 8'hC3;
            16'd5:   return 8'h07;
            default: return 8'h02;
        endcase
    endfunction

    function automatic logic [7:0] model_sum(input int upto);
        logic [7:0] s;
        s = 8'h00;
        for (int j = 0; j <= upto; j++) s = s + tape_mem[j];
        return s;
    endfunction

    function automatic logic [15:0] rand_exit();
        if ($urandom_range(0, 1) == 0) return 16'($urandom_range(0, 16'h0346));
        return 16'($urandom_range(16'h03C3, 16'hFFFF));
    endfunction

    task automatic expect_write(input int i);
        logic [13:0] a;
        a = 14'(i) + T_DEST;
        check($sformatf("wr_we[%0d]", i), ram_we, 1'b1);
        check($sformatf("wr_addr[%0d]", i), ram_addr, a);
        check($sformatf("wr_data[%0d]", i), ram_din, tape_mem[i]);
    endtask

    task automatic enter_copy(input int n);
        tick;
        tape_last  = 14'(n);
        tape_ready = 1'b1;
        cpu_addr   = T_TRAP;
        cpu_nm1    = 1'b0;
        smp;
        check("pre_trap_busy", busy, 1'b0);
        check("pre_trap_patch_sel", patch_sel, 1'b0);
        tick;
        cpu_nm1 = 1'b1;
        smp;
        check("entry_busy", busy, 1'b1);
        check("entry_rd_addr", tape_rd_addr, 14'd0);
        check("entry_no_we", ram_we, 1'b0);
    endtask

    // One load; a non-negative *_at index injects that event during the write of that byte.
    task automatic run_load(input int n, input logic [15:0] exit_a, input int conflict_at,
                            input int abort_at, input int drop_at, input int reset_at);
        int c0;
        int stop;
        stop = -1;
        c0 = wr_count;
        enter_copy(n);
        for (int i = 0; i <= n; i++) begin
            tick;
            cpu_addr   = T_TRAP + 16'($urandom_range(0, 6));
            cpu_ram_we = 1'b0;
            if (i == conflict_at) begin
                cpu_ram_we   = 1'b1;
                cpu_ram_addr = 14'h3FFF;
                cpu_dout     = 8'hA5;
                exp_conflict = 1'b1;
            end
            if (i == abort_at) begin
                cpu_addr = 16'h0010;
                cpu_nm1  = 1'b0;
            end
            if (i == drop_at) tape_ready = 1'b0;
            if (i == reset_at) reset = 1'b1;
            smp;
            expect_write(i);
            if (i != abort_at) check("copy_patch", patch_data, exp_patch(cpu_addr, 1'b1, 1'b1));
            if (i == abort_at || i == drop_at || i == reset_at) begin
                stop = i;
                break;
            end
        end
        tick;
        cpu_ram_we = 1'b0;
        cpu_nm1    = 1'b1;
        if (reset) begin
            reset = 1'b0;
            exp_conflict = 1'b0;
        end
        if (stop >= 0) begin
            cpu_addr = T_TRAP;
            smp;
            check("stop_busy", busy, 1'b0);
            check("stop_we", ram_we, 1'b0);
            check("stop_patch_sel", patch_sel, 1'b0);
            check("stop_abort", load_abort, (stop == reset_at) ? 1'b0 : 1'b1);
            check("stop_done", load_done, 1'b0);
`ifdef TAPE_DMA_CHECKSUM_EN
            check("stop_checksum", checksum, (stop == reset_at) ? 8'h00 : model_sum(stop));
`endif
            for (int k = 0; k < 3; k++) begin
                tick;
                smp;
                check("post_stop_we", ram_we, 1'b0);
            end
            check("stop_abort_clear", load_abort, 1'b0);
            check("stop_write_count", wr_count - c0, stop + 1);
            tick;
            cpu_ram_we   = 1'b1;
            cpu_ram_addr = 14'($urandom);
            cpu_dout     = 8'($urandom);
            smp;
            check("pass_we", ram_we, 1'b1);
            check("pass_addr", ram_addr, cpu_ram_addr);
            check("pass_din", ram_din, cpu_dout);
            tick;
            cpu_ram_we = 1'b0;
        end else begin
            cpu_addr = 16'h0348;
            smp;
            check("done_busy", busy, 1'b1);
            check("done_we", ram_we, 1'b0);
            check("done_patch_sel", patch_sel, 1'b1);
            check("done_patch_0348", patch_data, exp_patch(cpu_addr, 1'b0, 1'b1));
`ifdef TAPE_DMA_CHECKSUM_EN
            check("done_checksum", checksum, model_sum(n));
`endif
            tick;
            cpu_addr     = exit_a;
            cpu_nm1      = 1'b0;
            cpu_ram_we   = 1'b1;
            cpu_ram_addr = 14'($urandom);
            cpu_dout     = 8'($urandom);
            smp;
            check("exit_patch_sel", patch_sel, 1'b0);
            check("exit_patch_data", patch_data, 8'h00);
            check("exit_pass_we", ram_we, 1'b1);
            check("exit_pass_addr", ram_addr, cpu_ram_addr);
            check("exit_pass_din", ram_din, cpu_dout);
            tick;
            cpu_nm1    = 1'b1;
            cpu_ram_we = 1'b0;
            smp;
            check("load_done_pulse", load_done, 1'b1);
            check("load_abort_quiet", load_abort, 1'b0);
            check("idle_busy", busy, 1'b0);
            tick;
            smp;
            check("load_done_clear", load_done, 1'b0);
            check("write_count", wr_count - c0 - 1, n + 1);
        end
        check("cpu_conflict", cpu_conflict, exp_conflict);
    endtask

    initial begin
        int c0;
        reset        = 1'b1;
        cpu_addr     = T_TRAP;
        cpu_nm1      = 1'b1;
        cpu_ram_we   = 1'b0;
        cpu_ram_addr = 14'd0;
        cpu_dout     = 8'd0;
        tape_ready   = 1'b0;
        tape_last    = 14'd0;
        for (int j = 0; j < 16384; j++) tape_mem[j] = 8'h00;
        repeat (3) tick;
        reset = 1'b0;
        smp;
        check("rst_busy", busy, 1'b0);
        check("rst_patch_sel", patch_sel, 1'b0);
        check("rst_patch_data", patch_data, 8'h00);
        check("rst_load_done", load_done, 1'b0);
        check("rst_load_abort", load_abort, 1'b0);
        check("rst_conflict", cpu_conflict, 1'b0);
        check("rst_rd_addr", tape_rd_addr, 14'd0);
        check("rst_we", ram_we, 1'b0);
`ifdef TAPE_DMA_CHECKSUM_EN
        check("rst_checksum", checksum, 8'h00);
`endif

        // Directed load of 11,22,33,44, exit at 0207.
        tape_mem[0] = 8'h11; tape_mem[1] = 8'h22; tape_mem[2] = 8'h33; tape_mem[3] = 8'h44;
        run_load(3, 16'h0207, -1, -1, -1, -1);

        // No file ready: trap address is ignored.
        tick;
        tape_ready = 1'b0;
        cpu_addr   = T_TRAP;
        cpu_nm1    = 1'b0;
        c0 = wr_count;
        tick;
        cpu_nm1 = 1'b1;
        smp;
        check("noready_busy", busy, 1'b0);
        check("noready_patch_sel", patch_sel, 1'b0);
        repeat (3) tick;
        smp;
        check("noready_busy_later", busy, 1'b0);
        check("noready_writes", wr_count - c0, 0);

        // Abort by an M1 below the trap address in the middle of a long copy.
        for (int j = 0; j <= 200; j++) tape_mem[j] = 8'($urandom);
        run_load(100, 16'h0207, -1, int'($urandom_range(5, 60)), -1, -1);

        // Dropped CPU write during copy, then a normal finish.
        run_load(10, rand_exit(), 3, -1, -1, -1);

        // Tape buffer withdrawn mid-copy.
        run_load(20, rand_exit(), -1, -1, 7, -1);

        // Exit M1 coincides with the last write.
        run_load(5, rand_exit(), -1, 5, -1, -1);

        // Minimum-size file.
        run_load(0, rand_exit(), -1, -1, -1, -1);

        // Randomized loads.
        for (int r = 0; r < 6; r++) begin
            int n;
            n = int'($urandom_range(0, 40));
            for (int j = 0; j <= n; j++) tape_mem[j] = 8'($urandom);
            run_load(n, rand_exit(), -1, -1, -1, -1);
        end

        // Checksum-friendly load of 01..04.
        tape_mem[0] = 8'h01; tape_mem[1] = 8'h02; tape_mem[2] = 8'h03; tape_mem[3] = 8'h04;
        run_load(3, 16'h0207, -1, -1, -1, -1);

        // Reset at byte 50 of 200; also clears the sticky conflict flag.
        for (int j = 0; j <= 200; j++) tape_mem[j] = 8'($urandom);
        run_load(200, 16'h0207, -1, -1, -1, 50);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
